// File: rtl/icache_line_fill.sv
// icache_line_fill: read-side master for the synchronous instruction BROM.
// Accepts one line request per miss, issues LINE_WORDS back-to-back word reads
// and streams each returned word into the I-cache data array.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   req_valid/req_ready  miss request handshake (ready only when idle)
//   req_addr             miss word address (word-in-line bits ignored)
//   abort                cancels a fill in progress (level, combinational kill)
//   mem_addr/mem_cs      BROM read address / read enable
//   mem_dout             BROM data, valid the cycle after mem_cs
//   fill_we/idx/data     cache data-array write port
//   line_addr            line base address held for the tag write
//   done                 one-cycle pulse with the last word write
//   busy                 inverse of req_ready
module icache_line_fill #(
  parameter int unsigned AWIDTH     = 10,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned WIDX      = $clog2(LINE_WORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AWIDTH-1:0]      req_addr,
  input  logic                   abort,
  output logic [AWIDTH-1:0]      mem_addr,
  output logic                   mem_cs,
  input  logic [DWIDTH-1:0]      mem_dout,
  output logic                   fill_we,
  output logic [WIDX-1:0]        fill_idx,
  output logic [DWIDTH-1:0]      fill_data,
  output logic [AWIDTH-WIDX-1:0] line_addr,
  output logic                   done,
  output logic                   busy
);

  localparam int unsigned LWIDTH = AWIDTH - WIDX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDX-1:0]     cnt_q;
  logic [WIDX-1:0]     rd_idx_q;
  logic                rd_pend_q;
  logic [LWIDTH-1:0]   line_addr_q;
  logic [AWIDTH-1:0]   last_addr_q;
  logic                last_word;
  logic                accept;
  logic [AWIDTH-1:0]   issue_addr;

  // Word-in-line bits of the request address are don't-care (line aligned).
  logic unused_req_lsbs;
  assign unused_req_lsbs = ^req_addr[WIDX-1:0];

  assign last_word  = (cnt_q == WIDX'(LINE_WORDS - 1));
  assign accept     = (state_q == S_IDLE) && req_valid;
  assign issue_addr = {line_addr_q, cnt_q};

  // State register plus read-tracking datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_idx_q    <= '0;
      rd_pend_q   <= 1'b0;
      line_addr_q <= '0;
      last_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      // A write is owed next cycle only if a read actually went out this cycle
      rd_pend_q <= mem_cs;
      if (accept) begin
        line_addr_q <= req_addr[AWIDTH-1:WIDX];
        cnt_q       <= '0;
      end else if (state_q == S_ISSUE) begin
        rd_idx_q <= cnt_q;
        cnt_q    <= cnt_q + WIDX'(1);
      end
      // mem_addr keeps showing the last issued address outside ISSUE
      if (mem_cs) begin
        last_addr_q <= issue_addr;
      end
    end
  end

  // Next-state and control outputs; abort kills all strobes while filling
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_cs    = 1'b0;
    done      = 1'b0;
    fill_we   = rd_pend_q;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          fill_we = 1'b0;
          state_d = S_IDLE;
        end else begin
          mem_cs = 1'b1;
          if (last_word) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        if (abort) begin
          fill_we = 1'b0;
        end else begin
          done = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr  = (state_q == S_ISSUE) ? issue_addr : last_addr_q;
  assign fill_idx  = rd_idx_q;
  assign fill_data = mem_dout;
  assign line_addr = line_addr_q;
  assign busy      = ~req_ready;

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: BROM model holding mem[i] = i*0x11, a write
// scoreboard filled on request and drained by a fill_we monitor, plus
// cycle-exact checks of the handshake, read and done timing.
module tb_icache_line_fill;

  localparam int unsigned AWIDTH = 10;
  localparam int unsigned DWIDTH = 32;
  localparam int unsigned LW     = 4;
  localparam int unsigned WIDX   = 2;

  typedef struct {
    logic [WIDX-1:0]   idx;
    logic [DWIDTH-1:0] data;
  } wr_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid;
  logic                   req_ready;
  logic [AWIDTH-1:0]      req_addr;
  logic                   abort;
  logic [AWIDTH-1:0]      mem_addr;
  logic                   mem_cs;
  logic [DWIDTH-1:0]      mem_dout;
  logic                   fill_we;
  logic [WIDX-1:0]        fill_idx;
  logic [DWIDTH-1:0]      fill_data;
  logic [AWIDTH-WIDX-1:0] line_addr;
  logic                   done;
  logic                   busy;

  int  chk_cnt  = 0;
  int  pass_cnt = 0;
  wr_t sb[$];

  icache_line_fill #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .abort(abort), .mem_addr(mem_addr), .mem_cs(mem_cs),
    .mem_dout(mem_dout), .fill_we(fill_we), .fill_idx(fill_idx),
    .fill_data(fill_data), .line_addr(line_addr), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DWIDTH-1:0] brom(input logic [AWIDTH-1:0] a);
    return DWIDTH'({22'd0, a} * 32'd17);
  endfunction

  // Synchronous BROM, one-cycle latency, read only when selected
  always @(posedge clk) begin
    if (mem_cs) mem_dout <= brom(mem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Every write must match the next expected word of the current line
  always begin
    @(negedge clk);
    #2;
    if (fill_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("we_unexpected", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("fill_idx", 64'(fill_idx), 64'(e.idx));
        check("fill_data", 64'(fill_data), 64'(e.data));
      end
    end
  end

  // Called at a negedge while idle; returns at a negedge back in idle.
  // ab = cycle in which abort is raised (0 = none); hold keeps req_valid high.
  task automatic do_fill(input logic [AWIDTH-1:0] addr, input int ab, input bit hold);
    logic [AWIDTH-1:0] base;
    bit live;
    int writes;
    base = {addr[AWIDTH-1:WIDX], 2'b00};
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < int'(LW); i++) begin
      wr_t e;
      e.idx  = WIDX'(i);
      e.data = brom(base + AWIDTH'(i));
      sb.push_back(e);
    end
    live = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) req_valid = 1'b0;
      if (hold) req_addr = ~addr;
      abort = (c == ab);
      #1;
      live = (ab == 0) || (c < ab);
      check("mem_cs", 64'(mem_cs), 64'((c <= 4) && live));
      if (c <= 4 && live) check("mem_addr", 64'(mem_addr), 64'(base + AWIDTH'(c - 1)));
      check("fill_we", 64'(fill_we), 64'((c >= 2) && (c <= 5) && live));
      check("done", 64'(done), 64'((c == 5) && live));
      check("req_ready", 64'(req_ready), 64'(((ab != 0) && (c > ab)) || (c == 6)));
      if (c == 1) check("line_addr", 64'(line_addr), 64'(addr[AWIDTH-1:WIDX]));
      if (((ab != 0) && (c == ab + 1)) || c == 6) break;
    end
    abort  = 1'b0;
    writes = (ab == 0) ? 4 : ((ab > 2) ? ab - 2 : 0);
    check("sb_left", 64'(sb.size()), 64'(4 - writes));
    sb.delete();
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    abort     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_cs", 64'(mem_cs), 64'd0);
    check("rst_fill_we", 64'(fill_we), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    do_fill(10'h012, 0, 1'b0);   // basic line fill
    do_fill(10'h3FF, 0, 1'b0);   // top line of the address space
    do_fill(10'h040, 3, 1'b0);   // abort mid-issue
    do_fill(10'h080, 0, 1'b0);   // recovery after abort
    do_fill(10'h100, 5, 1'b0);   // abort together with the last write
    do_fill(10'h1C4, 0, 1'b1);   // req_valid held through the fill
    do_fill(10'h200, 0, 1'b0);   // held request taken in cycle 6

    // Reset in the middle of a fill
    check("mid_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = 10'h155;
    for (int i = 0; i < int'(LW); i++) begin
      wr_t e;
      e.idx  = WIDX'(i);
      e.data = brom(10'h154 + AWIDTH'(i));
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_we_before", 64'(fill_we), 64'd1);
    @(negedge clk);
    #1;
    check("mid_mem_cs", 64'(mem_cs), 64'd0);
    check("mid_fill_we", 64'(fill_we), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_req_ready", 64'(req_ready), 64'd1);
    check("mid_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_line_addr", 64'(line_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mid_done_after", 64'(done), 64'd0);
    check("mid_we_after", 64'(fill_we), 64'd0);
    check("mid_sb_left", 64'(sb.size()), 64'd3);
    sb.delete();

    do_fill(10'h2A8, 0, 1'b0);   // clean fill after reset

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
